// File: rtl/sr_excite_gen_if.sv
// Bus between a pattern source and sr_excite_gen; q_fb/mismatch exist only
// when SR_FB_CHECK_EN is defined.
interface sr_excite_gen_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             s;
  logic             r;
  logic             busy;
  logic             done;
  logic             q_model;
  logic [CNT_W-1:0] set_cnt;
  logic [CNT_W-1:0] rst_cnt;
`ifdef SR_FB_CHECK_EN
  logic             q_fb;
  logic             mismatch;

  modport master (
    output start, pattern, q_fb,
    input  s, r, busy, done, q_model, set_cnt, rst_cnt, mismatch
  );
  modport slave (
    input  start, pattern, q_fb,
    output s, r, busy, done, q_model, set_cnt, rst_cnt, mismatch
  );
`else
  modport master (
    output start, pattern,
    input  s, r, busy, done, q_model, set_cnt, rst_cnt
  );
  modport slave (
    input  start, pattern,
    output s, r, busy, done, q_model, set_cnt, rst_cnt
  );
`endif
endinterface

// File: rtl/sr_excite_gen.sv
// SR flip-flop excitation generator: turns a target Q sequence into s/r drive.
// Optional feedback compare against sr_ff Q when SR_FB_CHECK_EN is defined.
module sr_excite_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic           clk,
  input logic           reset,
  sr_excite_gen_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_PULSE} state_e;

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             s_q, s_d, r_q, r_d;
  logic             q_q, q_d;
  logic [CNT_W-1:0] set_q, set_d, rst_q, rst_d;
  logic             qp, t, start_acc;

  // ST_DONE shows the last bit's drive; ST_PULSE is the done cycle
  always_comb begin
    qp        = s_q ? 1'b1 : (r_q ? 1'b0 : q_q);
    t         = shreg_q[idx_q];
    start_acc = (state_q == ST_IDLE) && bus.start;
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    q_d       = qp;
    set_d     = set_q;
    rst_d     = rst_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.pattern;
          idx_d   = '0;
          set_d   = '0;
          rst_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (t && !qp) begin
          s_d = 1'b1;
          if (set_q != CNT_MAX) set_d = set_q + 1'b1;
        end else if (!t && qp) begin
          r_d = 1'b1;
          if (rst_q != CNT_MAX) rst_d = rst_q + 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_PULSE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      q_q     <= 1'b0;
      set_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      r_q     <= r_d;
      q_q     <= q_d;
      set_q   <= set_d;
      rst_q   <= rst_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.r       = r_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_PULSE);
  assign bus.q_model = q_q;
  assign bus.set_cnt = set_q;
  assign bus.rst_cnt = rst_q;

`ifdef SR_FB_CHECK_EN
  logic mis_q, mis_d, mis_now;

  // Live compare is OR'd in so a divergence shows in the cycle it appears
  always_comb begin
    mis_now = mis_q | ((state_q != ST_IDLE) && (bus.q_fb != q_q));
    mis_d   = start_acc ? 1'b0 : mis_now;
  end

  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign bus.mismatch = mis_now;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif
endmodule

// File: tb/tb_sr_excite_gen.sv
// Scoreboard bench for sr_excite_gen; per-cycle expectations are built from
// the target pattern and the Q latency, then compared after each clock edge.
module tb_sr_excite_gen;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  logic mq;
  logic [12:0] sb[$];
  logic [12:0] exp_v;

  sr_excite_gen_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sr_excite_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs_vec();
    return {bus.s, bus.r, bus.busy, bus.done, bus.q_model, bus.set_cnt, bus.rst_cnt};
  endfunction

  function automatic logic [12:0] mk(input logic s, input logic r, input logic b,
                                     input logic d, input logic q,
                                     input logic [3:0] sc, input logic [3:0] rc);
    return {s, r, b, d, q, sc, rc};
  endfunction

  // Q reaches pattern[k-1] by the edge that issues bit k; drive follows from that
  task automatic push_run(input logic [W-1:0] p);
    logic [3:0] sc, rc;
    logic       qk, t;
    sc = '0;
    rc = '0;
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, mq, 4'd0, 4'd0));
    for (int k = 0; k < W; k++) begin
      qk = (k == 0) ? mq : p[k-1];
      t  = p[k];
      if (t && !qk && sc != 4'hF) sc++;
      if (!t && qk && rc != 4'hF) rc++;
      sb.push_back(mk(t & ~qk, ~t & qk, 1'b1, 1'b0, qk, sc, rc));
    end
    sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, p[W-1], sc, rc));
    sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, p[W-1], sc, rc));
    mq = p[W-1];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) sb.push_back('0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      n_vec++;
      if (obs_vec() !== exp_v) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %b required %b", i, obs_vec(), exp_v);
      end
    end
    reset = 1'b0;
    mq    = 1'b0;
  endtask

  task automatic test_pattern(input logic [W-1:0] p, input string tag);
    bus.start   = 1'b1;
    bus.pattern = p;
    push_run(p);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_v = sb.pop_front();
      n_vec++;
      if (obs_vec() !== exp_v) begin
        n_err++;
        $display("FAIL %s cyc%0d: got %b required %b", tag, i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_known_counts();
    test_pattern(8'b1010_0110, "pat_a6");
    n_vec++;
    if ({bus.set_cnt, bus.rst_cnt, bus.q_model} !== {4'd3, 4'd2, 1'b1}) begin
      n_err++;
      $display("FAIL a6_totals: got set=%0d rst=%0d q=%b required set=3 rst=2 q=1",
               bus.set_cnt, bus.rst_cnt, bus.q_model);
    end
    test_pattern(8'h00, "pat_00");
    n_vec++;
    if ({bus.set_cnt, bus.rst_cnt, bus.q_model} !== {4'd0, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL 00_totals: got set=%0d rst=%0d q=%b required set=0 rst=1 q=0",
               bus.set_cnt, bus.rst_cnt, bus.q_model);
    end
  endtask

  task automatic test_back_to_back();
    bus.start   = 1'b1;
    bus.pattern = 8'h3C;
    push_run(8'h3C);
    for (int i = 0; i < 2 * (W + 3); i++) begin
      @(posedge clk); #1;
      if (i == 0) bus.pattern = 8'hFF;
      if (i == W + 2) push_run(8'hFF);
      if (i == W + 3) bus.start = 1'b0;
      exp_v = sb.pop_front();
      n_vec++;
      if (obs_vec() !== exp_v) begin
        n_err++;
        $display("FAIL b2b cyc%0d: got %b required %b", i, obs_vec(), exp_v);
      end
    end
  endtask

  task automatic test_reset_abort();
    bus.start   = 1'b1;
    bus.pattern = 8'hAA;
    push_run(8'hAA);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_v = sb.pop_front();
      n_vec++;
      if (obs_vec() !== exp_v) begin
        n_err++;
        $display("FAIL abort_pre cyc%0d: got %b required %b", i, obs_vec(), exp_v);
      end
    end
    sb.delete();
    reset = 1'b1;
    for (int i = 0; i < 13; i++) sb.push_back('0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      exp_v = sb.pop_front();
      n_vec++;
      if (obs_vec() !== exp_v) begin
        n_err++;
        $display("FAIL abort_post cyc%0d: got %b required %b", i, obs_vec(), exp_v);
      end
    end
    mq = 1'b0;
  endtask

`ifdef SR_FB_CHECK_EN
  task automatic test_fb_check();
    logic mexp[$];
    logic m;
    bus.q_fb    = 1'b0;
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    push_run(8'hFF);
    for (int i = 0; i < W + 3; i++) mexp.push_back(i >= 2);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_v = sb.pop_front();
      m     = mexp.pop_front();
      n_vec++;
      if ({obs_vec(), bus.mismatch} !== {exp_v, m}) begin
        n_err++;
        $display("FAIL fb_forced cyc%0d: got %b/%b required %b/%b",
                 i, obs_vec(), bus.mismatch, exp_v, m);
      end
    end
    bus.q_fb    = 1'b1;
    bus.start   = 1'b1;
    push_run(8'hFF);
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_v = sb.pop_front();
      n_vec++;
      if ({obs_vec(), bus.mismatch} !== {exp_v, 1'b0}) begin
        n_err++;
        $display("FAIL fb_clear cyc%0d: got %b/%b required %b/0",
                 i, obs_vec(), bus.mismatch, exp_v);
      end
    end
  endtask
`endif

  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
`ifdef SR_FB_CHECK_EN
    bus.q_fb    = 1'b0;
`endif
    mq = 1'b0;
    test_reset();
    test_known_counts();
    test_pattern(8'h5A, "pat_5a");
    test_back_to_back();
    test_reset_abort();
    test_pattern(8'hC3, "pat_c3");
`ifdef SR_FB_CHECK_EN
    test_fb_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
